frequency_generator: RTL and testbench
======================================

// Module: frequency_generator
// PURPOSE
//  Programmable square-wave source, the stimulus-side counterpart of the frequency meter.
//  Accepts a target frequency in Hz and drives a 50%-duty square wave at that rate.
//  Computes half-period = CLK_HZ/(2*freq) with an on-block sequential restoring divider.
//  active_freq feeds the 7-segment Switcher; wave_out loops back to a meter input for self-test.
// PARAMETERS
//  CLK_HZ   50000000  system clock frequency in Hz
//  FREQ_W   10        width of frequency word (max 1023 Hz)
//  CNT_W    26        width of dividend/quotient/half-period counter; CLK_HZ/2 must fit
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset        in   1       asynchronous, active-high; clears every register
//  freq_in      in   FREQ_W  requested frequency in Hz, sampled on accepted load
//  load         in   1       request: apply freq_in; accepted only when ready=1
//  ready        out  1       1 in IDLE and RUN, 0 in DIVIDE
//  wave_out     out  1       square wave output (registered)
//  active_freq  out  FREQ_W  frequency currently being generated (0 = stopped)
//  cycle_done   out  1       one-cycle pulse coincident with each 0->1 transition of wave_out
// BEHAVIOUR
//  Reset: state=IDLE, wave_out=0, ready=1, active_freq=0, cycle_done=0, counters/half=0.
//  States: IDLE (no output), DIVIDE (computing), RUN (generating).
//  Load accepted on a clk edge where load=1 and ready=1; freq_in latched as pending_freq.
//   - pending_freq==0: next state IDLE, wave_out<=0, counter<=0, active_freq<=0. No divide.
//   - pending_freq!=0: next state DIVIDE.
//  load while ready=0 is ignored (no queuing).
//  DIVIDE: restoring divide of CLK_HZ/2 (CNT_W bits) by pending_freq, one quotient bit
//   per cycle, exactly CNT_W cycles. Remainder discarded (truncate).
//   Quotient==0 is clamped to 1 (max output rate CLK_HZ/2).
//  Divide complete, came from IDLE: enter RUN; half<=quotient, counter<=0, wave_out<=1,
//   cycle_done pulses that cycle, active_freq<=pending_freq.
//  Divide complete, came from RUN: wave keeps running on the old half-period throughout;
//   new quotient held as pending_half, applied at the next toggle (glitch-free change).
//   active_freq updates in the same cycle the new half is applied.
//  RUN: counter increments each cycle; when counter==half-1: wave_out toggles, counter<=0,
//   half<=pending_half if one is waiting. cycle_done=1 only when toggle is 0->1.
//  Period = 2*half cycles exactly; high and low phases each = half cycles.
//  Counter never exceeds half-1; no wrap-around beyond CNT_W possible by construction.
//  Load of 0 while in RUN: stops immediately (wave_out<=0 next edge), no phase completion.
//  Load accepted in RUN on the same cycle as a toggle: toggle happens with old half;
//   the new value enters DIVIDE normally.
//  A second load arriving during the divide started from RUN is ignored (ready=0).
//  Reset mid-DIVIDE or mid-RUN: immediate return to reset values; partial quotient lost.
// TESTING  (bench uses CLK_HZ=1000, CNT_W=10)
//  1 reset, idle 50 cycles -> wave_out=0, ready=1, active_freq=0, no cycle_done.
//  2 load freq_in=5 -> ready low exactly 10 cycles; then wave high 100 / low 100 cycles,
//    cycle_done every 200 cycles, active_freq=5.
//  3 load freq_in=600 (quotient 0) -> clamped: wave_out toggles every cycle, period 2.
//  4 running at 5 Hz, load 10 mid-high-phase -> current high phase completes at 100 cycles,
//    subsequent phases 50 cycles; active_freq changes 5->10 at that toggle; no runt pulse.
//  5 load during DIVIDE (ready=0) with freq_in=1 -> ignored; result matches first request.
//  6 load 0 while running -> wave_out=0 next edge, active_freq=0; assert reset mid-DIVIDE
//    -> all outputs at reset values on the same edge, ready=1.

Source files
------------

// File: rtl/frequency_generator.sv
// ---------------------------------------------------------------------------
// frequency_generator
//
// Programmable 50%-duty square-wave source. A requested frequency in Hz is
// turned into a half-period (CLK_HZ / (2 * freq) clock cycles) by an on-block
// restoring divider that produces one quotient bit per cycle. The wave is then
// generated by a half-period counter. A frequency change made while the wave
// is running waits for the next toggle to take effect, so no runt pulses occur.
//
// Ports
//   clk          in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-high, clears every register
//   freq_in      in   FREQ_W  requested frequency in Hz, sampled on accepted load
//   load         in   1       apply freq_in; only accepted while ready = 1
//   ready        out  1       1 in IDLE and RUN, 0 while dividing
//   wave_out     out  1       registered square wave
//   active_freq  out  FREQ_W  frequency currently generated (0 = stopped)
//   cycle_done   out  1       one-cycle pulse with each 0->1 edge of wave_out
// ---------------------------------------------------------------------------
module frequency_generator #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned FREQ_W = 10,
    parameter int unsigned CNT_W  = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              load,
    output logic              ready,
    output logic              wave_out,
    output logic [FREQ_W-1:0] active_freq,
    output logic              cycle_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_RUN
    } state_t;

    localparam int unsigned      BIT_W    = $clog2(CNT_W + 1);
    localparam logic [CNT_W-1:0] HALF_CLK = CNT_W'(CLK_HZ / 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);

    state_t              state_q, state_d;
    logic                wave_q, wave_d;
    logic                cycle_done_q, cycle_done_d;
    logic [FREQ_W-1:0]   active_freq_q, active_freq_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic [CNT_W-1:0]    half_q, half_d;
    logic [CNT_W-1:0]    pending_half_q, pending_half_d;
    logic [FREQ_W-1:0]   pending_active_q, pending_active_d;
    logic                pending_valid_q, pending_valid_d;
    logic [FREQ_W-1:0]   pending_freq_q, pending_freq_d;
    logic                from_run_q, from_run_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [FREQ_W-1:0]   rem_q, rem_d;
    logic [CNT_W-2:0]    quo_q, quo_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;

    logic [FREQ_W:0]     trial;
    logic                fits;
    logic [CNT_W-1:0]    quo_next;
    logic [CNT_W-1:0]    quo_final;
    logic                toggle_now;
    logic                wave_active;
    logic                accept;

    // Next-state logic. The wave keeps running during a divide that was
    // started from RUN, so the wave step is applied first and the load /
    // divide handling below may override it.
    always_comb begin
        state_d          = state_q;
        wave_d           = wave_q;
        cycle_done_d     = 1'b0;
        active_freq_d    = active_freq_q;
        counter_d        = counter_q;
        half_d           = half_q;
        pending_half_d   = pending_half_q;
        pending_active_d = pending_active_q;
        pending_valid_d  = pending_valid_q;
        pending_freq_d   = pending_freq_q;
        from_run_d       = from_run_q;
        div_d            = div_q;
        rem_d            = rem_q;
        quo_d            = quo_q;
        bit_cnt_d        = bit_cnt_q;

        // One restoring-divide step: shift in the next dividend bit and
        // subtract the divisor when it fits. The remainder stays below the
        // divisor, so FREQ_W bits hold it between steps.
        trial     = {rem_q, div_q[CNT_W-1]};
        fits      = (trial >= {1'b0, pending_freq_q});
        quo_next  = {quo_q, fits};
        quo_final = (quo_next == '0) ? CNT_W'(1) : quo_next;

        toggle_now  = (counter_q == half_q - CNT_W'(1));
        wave_active = (state_q == ST_RUN) || ((state_q == ST_DIVIDE) && from_run_q);
        accept      = load && (state_q != ST_DIVIDE);

        if (wave_active) begin
            if (toggle_now) begin
                wave_d       = ~wave_q;
                cycle_done_d = ~wave_q;
                counter_d    = '0;
                // A waiting half-period only takes effect on a toggle.
                if (pending_valid_q) begin
                    half_d          = pending_half_q;
                    active_freq_d   = pending_active_q;
                    pending_valid_d = 1'b0;
                end
            end else begin
                counter_d = counter_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept) begin
                    pending_freq_d = freq_in;
                    if (freq_in == '0) begin
                        // Stop at once, abandoning any phase in progress.
                        state_d         = ST_IDLE;
                        wave_d          = 1'b0;
                        cycle_done_d    = 1'b0;
                        counter_d       = '0;
                        active_freq_d   = '0;
                        pending_valid_d = 1'b0;
                    end else begin
                        state_d    = ST_DIVIDE;
                        from_run_d = (state_q == ST_RUN);
                        div_d      = HALF_CLK;
                        rem_d      = '0;
                        quo_d      = '0;
                        bit_cnt_d  = '0;
                    end
                end
            end

            ST_DIVIDE: begin
                div_d     = {div_q[CNT_W-2:0], 1'b0};
                rem_d     = fits ? FREQ_W'(trial - {1'b0, pending_freq_q})
                                 : trial[FREQ_W-1:0];
                quo_d     = quo_next[CNT_W-2:0];
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_RUN;
                    if (from_run_q) begin
                        pending_half_d   = quo_final;
                        pending_active_d = pending_freq_q;
                        pending_valid_d  = 1'b1;
                    end else begin
                        half_d          = quo_final;
                        counter_d       = '0;
                        wave_d          = 1'b1;
                        cycle_done_d    = 1'b1;
                        active_freq_d   = pending_freq_q;
                        pending_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            wave_q           <= 1'b0;
            cycle_done_q     <= 1'b0;
            active_freq_q    <= '0;
            counter_q        <= '0;
            half_q           <= '0;
            pending_half_q   <= '0;
            pending_active_q <= '0;
            pending_valid_q  <= 1'b0;
            pending_freq_q   <= '0;
            from_run_q       <= 1'b0;
            div_q            <= '0;
            rem_q            <= '0;
            quo_q            <= '0;
            bit_cnt_q        <= '0;
        end else begin
            state_q          <= state_d;
            wave_q           <= wave_d;
            cycle_done_q     <= cycle_done_d;
            active_freq_q    <= active_freq_d;
            counter_q        <= counter_d;
            half_q           <= half_d;
            pending_half_q   <= pending_half_d;
            pending_active_q <= pending_active_d;
            pending_valid_q  <= pending_valid_d;
            pending_freq_q   <= pending_freq_d;
            from_run_q       <= from_run_d;
            div_q            <= div_d;
            rem_q            <= rem_d;
            quo_q            <= quo_d;
            bit_cnt_q        <= bit_cnt_d;
        end
    end

    assign ready       = (state_q != ST_DIVIDE);
    assign wave_out    = wave_q;
    assign active_freq = active_freq_q;
    assign cycle_done  = cycle_done_q;

endmodule

// File: tb/tb_frequency_generator.sv
// ---------------------------------------------------------------------------
// tb_frequency_generator
//
// Bench for frequency_generator with CLK_HZ = 1000 and CNT_W = 10, so the
// dividend is 500. Stimulus queues the wave edges it expects (level, length
// of the phase that just ended, active_freq); a monitor watches wave_out on
// every falling clock edge and checks each edge it sees against the queue.
// ---------------------------------------------------------------------------
module tb_frequency_generator;

    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned FREQ_W = 10;
    localparam int unsigned CNT_W  = 10;

    typedef struct {
        logic              level;
        int                len;
        logic              chk_len;
        logic [FREQ_W-1:0] freq;
    } edge_t;

    logic              clk;
    logic              reset;
    logic [FREQ_W-1:0] freq_in;
    logic              load;
    logic              ready;
    logic              wave_out;
    logic [FREQ_W-1:0] active_freq;
    logic              cycle_done;

    edge_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    frequency_generator #(
        .CLK_HZ (CLK_HZ),
        .FREQ_W (FREQ_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .freq_in     (freq_in),
        .load        (load),
        .ready       (ready),
        .wave_out    (wave_out),
        .active_freq (active_freq),
        .cycle_done  (cycle_done)
    );

    // 10-time-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus acts 1 unit after each falling edge, after the monitor sampled.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pulse load for one clock with the given frequency.
    task automatic applyStimulus(input logic [FREQ_W-1:0] f);
        freq_in = f;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    task automatic expectEdge(input logic level, input int len, input logic chk_len,
                              input logic [FREQ_W-1:0] f);
        edge_t e;
        e.level   = level;
        e.len     = len;
        e.chk_len = chk_len;
        e.freq    = f;
        exp_q.push_back(e);
    endtask

    // Wait until the monitor has consumed every queued edge, bounded in cycles.
    task automatic drainQueue(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s: %0d expected edges never seen within %0d cycles (expected 0 left)",
                     name, exp_q.size(), max_cycles);
            exp_q.delete();
        end
    endtask

    // Monitor: measures phase lengths and checks every wave edge.
    initial begin
        logic  prev_wave;
        int    run_len;
        edge_t e;
        prev_wave = 1'b0;
        run_len   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wave = 1'b0;
                run_len   = 0;
            end else if (wave_out !== prev_wave) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_edge: wave_out=%0b after %0d cycles, expected no edge",
                             wave_out, run_len);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (wave_out !== e.level) begin
                        failures++;
                        $display("[TB] FAIL edge_level: got %0b, expected %0b", wave_out, e.level);
                    end
                    if (e.chk_len) begin
                        checks++;
                        if (run_len != e.len) begin
                            failures++;
                            $display("[TB] FAIL phase_len: got %0d cycles, expected %0d", run_len, e.len);
                        end
                    end
                    checks++;
                    if (active_freq !== e.freq) begin
                        failures++;
                        $display("[TB] FAIL edge_active_freq: got %0d, expected %0d", active_freq, e.freq);
                    end
                    checks++;
                    if (cycle_done !== e.level) begin
                        failures++;
                        $display("[TB] FAIL edge_cycle_done: got %0b, expected %0b", cycle_done, e.level);
                    end
                end
                prev_wave = wave_out;
                run_len   = 1;
            end else begin
                run_len++;
                if (cycle_done !== 1'b0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spurious_cycle_done: got %0b without rising edge, expected 0",
                             cycle_done);
                end
            end
        end
    end

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cd_count;
        int n;
        reset   = 1'b1;
        load    = 1'b0;
        freq_in = '0;
        repeat (3) step();
        reset = 1'b0;

        // Idle after reset: nothing moves for 50 cycles.
        cd_count = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (cycle_done) cd_count++;
        end
        checkOutput("idle_wave", int'(wave_out), 0);
        checkOutput("idle_ready", int'(ready), 1);
        checkOutput("idle_active_freq", int'(active_freq), 0);
        checkOutput("idle_cycle_done_count", cd_count, 0);

        // 5 Hz: half = 500/5 = 100 cycles.
        $display("[TB] start 5 Hz");
        expectEdge(1'b1, 0,   1'b0, 10'd5);
        expectEdge(1'b0, 100, 1'b1, 10'd5);
        expectEdge(1'b1, 100, 1'b1, 10'd5);
        expectEdge(1'b0, 100, 1'b1, 10'd5);
        expectEdge(1'b1, 100, 1'b1, 10'd5);
        applyStimulus(10'd5);
        n = 0;
        while (ready == 1'b0 && n < 100) begin
            n++;
            step();
        end
        checkOutput("divide_latency", n, 10);
        checkOutput("active_after_divide", int'(active_freq), 5);
        drainQueue("run_5hz", 1000);

        // Change to 10 Hz part-way through a high phase: the old phase
        // finishes at 100 cycles, then phases of 500/10 = 50 cycles.
        $display("[TB] change 5 Hz -> 10 Hz mid-phase");
        repeat (20) step();
        expectEdge(1'b0, 100, 1'b1, 10'd10);
        expectEdge(1'b1, 50,  1'b1, 10'd10);
        expectEdge(1'b0, 50,  1'b1, 10'd10);
        expectEdge(1'b1, 50,  1'b1, 10'd10);
        applyStimulus(10'd10);
        checkOutput("busy_ready_from_run", int'(ready), 0);
        checkOutput("active_before_apply", int'(active_freq), 5);
        drainQueue("run_10hz", 500);

        // 600 Hz: 500/600 truncates to 0 and is clamped to 1 cycle per phase.
        $display("[TB] change to 600 Hz (clamped)");
        expectEdge(1'b0, 50, 1'b1, 10'd600);
        for (int i = 0; i < 7; i++) begin
            expectEdge((i % 2) == 0, 1, 1'b1, 10'd600);
        end
        applyStimulus(10'd600);
        drainQueue("run_clamped", 300);

        // Load 0 right after a rising edge: wave drops on the next edge.
        $display("[TB] stop while running");
        expectEdge(1'b0, 1, 1'b1, 10'd0);
        applyStimulus(10'd0);
        checkOutput("stop_wave", int'(wave_out), 0);
        checkOutput("stop_active_freq", int'(active_freq), 0);
        checkOutput("stop_ready", int'(ready), 1);
        repeat (20) step();
        drainQueue("stop", 5);

        // Reset in the middle of a divide: outputs return to reset values at once.
        $display("[TB] reset mid-divide");
        applyStimulus(10'd7);
        repeat (3) step();
        checkOutput("divide_ready_low", int'(ready), 0);
        reset = 1'b1;
        #1;
        checkOutput("reset_ready", int'(ready), 1);
        checkOutput("reset_wave", int'(wave_out), 0);
        checkOutput("reset_active_freq", int'(active_freq), 0);
        checkOutput("reset_cycle_done", int'(cycle_done), 0);
        step();
        reset = 1'b0;
        repeat (15) step();
        checkOutput("after_reset_ready", int'(ready), 1);
        checkOutput("after_reset_active_freq", int'(active_freq), 0);

        // A load during the divide is ignored: 20 Hz (half 25) wins over 1 Hz.
        $display("[TB] load ignored during divide");
        expectEdge(1'b1, 0,  1'b0, 10'd20);
        expectEdge(1'b0, 25, 1'b1, 10'd20);
        expectEdge(1'b1, 25, 1'b1, 10'd20);
        applyStimulus(10'd20);
        repeat (3) step();
        checkOutput("second_load_ready", int'(ready), 0);
        applyStimulus(10'd1);
        drainQueue("run_20hz", 200);
        checkOutput("ignored_load_active", int'(active_freq), 20);
        expectEdge(1'b0, 1, 1'b1, 10'd0);
        applyStimulus(10'd0);
        drainQueue("stop_20hz", 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
